// File: rtl/cdc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cdc_pkg : shared state encoding and default widths for the CDC rx path
// Rev 1.0
// ---------------------------------------------------------------------------
package cdc_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sync_block.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_block : multi-flop synchronizer followed by one output retiming flop
// Rev 1.0
// ---------------------------------------------------------------------------
module sync_block #(
  parameter int C_NUM_SYNC_REGS = 5
) (
  input  logic clk,
  input  logic data_in,
  output logic data_out
);

  // No reset: the chain must keep tracking the source level through reset.
  logic [C_NUM_SYNC_REGS-1:0] sync_chain;
  logic                       out_reg;

  always_ff @(posedge clk) begin
    sync_chain <= {sync_chain[C_NUM_SYNC_REGS-2:0], data_in};
    out_reg    <= sync_chain[C_NUM_SYNC_REGS-1];
  end

  assign data_out = out_reg;

endmodule
`default_nettype wire

// File: rtl/cdc_handshake_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cdc_handshake_rx : receive side of a toggle req/ack crossing, valid/ready out
// Rev 1.0
// ---------------------------------------------------------------------------
module cdc_handshake_rx
  import cdc_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int C_NUM_SYNC_REGS = 5,
  parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_tog_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ack_tog_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic [CNT_WIDTH-1:0]  xfer_count,
  output logic                  err_sticky,
  input  logic                  err_clr
);

  localparam int INIT_W = $clog2(C_NUM_SYNC_REGS + 1) + 1;
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(C_NUM_SYNC_REGS);

  logic              req_sync;
  logic              req_sync_d;
  logic              req_edge;
  logic [INIT_W-1:0] init_cnt;
  state_t            state;

  sync_block #(
    .C_NUM_SYNC_REGS (C_NUM_SYNC_REGS)
  ) u_sync_req (
    .clk      (clk),
    .data_in  (req_tog_in),
    .data_out (req_sync)
  );

  assign req_edge = req_sync ^ req_sync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_INIT;
      init_cnt    <= '0;
      req_sync_d  <= 1'b0;
      ack_tog_out <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      xfer_count  <= '0;
      err_sticky  <= 1'b0;
    end else begin
      req_sync_d <= req_sync;
      if (err_clr) begin
        err_sticky <= 1'b0;
      end

      case (state)
        ST_INIT: begin
          // Realign ack to whatever level the source is parked at.
          if (init_cnt == INIT_LAST) begin
            ack_tog_out <= req_sync;
            state       <= ST_IDLE;
          end else begin
            init_cnt <= init_cnt + INIT_W'(1);
          end
        end

        ST_IDLE: begin
          if (req_edge) begin
            data_out   <= data_in;
            data_valid <= 1'b1;
            state      <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          // A new request while a word is held is dropped; the later
          // assignment lets the violation win over err_clr.
          if (req_edge) begin
            err_sticky <= 1'b1;
          end
          if (data_valid && data_ready) begin
            data_valid  <= 1'b0;
            ack_tog_out <= ~ack_tog_out;
            xfer_count  <= xfer_count + CNT_WIDTH'(1);
            state       <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cdc_handshake_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cdc_handshake_rx : self-checking bench for cdc_handshake_rx (CNT_WIDTH=4)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_cdc_handshake_rx;

  localparam int DW  = 32;
  localparam int NS  = 5;
  localparam int CW  = 4;
  localparam int LAT = NS + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_tog_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          ack_tog_out;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          data_ready = 1'b0;
  logic [CW-1:0] xfer_count;
  logic          err_sticky;
  logic          err_clr = 1'b0;

  int   tests = 0;
  int   fails = 0;
  logic exp_ack = 1'b0;
  int   exp_cnt = 0;

  always #5 clk = ~clk;

  cdc_handshake_rx #(
    .DATA_WIDTH      (DW),
    .C_NUM_SYNC_REGS (NS),
    .CNT_WIDTH       (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_tog_in  (req_tog_in),
    .data_in     (data_in),
    .ack_tog_out (ack_tog_out),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .xfer_count  (xfer_count),
    .err_sticky  (err_sticky),
    .err_clr     (err_clr)
  );

  typedef struct {
    logic [31:0] data;
    int          bp;
    int          cnt_after;
    logic        ack_after;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!data_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  // One complete transfer with bp cycles of backpressure after valid.
  task automatic do_xfer(input logic [31:0] d, input int bp);
    int n;
    data_in    = d;
    req_tog_in = ~req_tog_in;
    data_ready = (bp == 0);
    wait_valid(n);
    chk("latency", n, LAT);
    chk("capture", data_out, d);
    for (int i = 0; i < bp; i++) begin
      tick();
      chk("bp_valid", data_valid, 1'b1);
      chk("bp_data", data_out, d);
      chk("bp_ack", ack_tog_out, exp_ack);
    end
    data_ready = 1'b1;
    tick();
    exp_ack = ~exp_ack;
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    chk("acc_valid", data_valid, 1'b0);
    chk("acc_ack", ack_tog_out, exp_ack);
    chk("acc_cnt", xfer_count, exp_cnt);
    data_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{32'hDEADBEEF, 0, 1, 1'b1};
    vecs[1] = '{32'hCAFEF00D, 20, 2, 1'b0};
    vecs[2] = '{32'h00000000, 1, 3, 1'b1};
    vecs[3] = '{32'hFFFFFFFF, 3, 4, 1'b0};

    // Reset and idle
    repeat (8) tick();
    rst_n = 1'b1;
    repeat (8) tick();
    chk("rst_ack", ack_tog_out, 1'b0);
    chk("rst_valid", data_valid, 1'b0);
    chk("rst_cnt", xfer_count, 0);
    chk("rst_err", err_sticky, 1'b0);
    chk("rst_data", data_out, 0);

    // Table-driven transfers (single, long backpressure, short backpressure)
    for (int i = 0; i < 4; i++) begin
      do_xfer(vecs[i].data, vecs[i].bp);
      chk("tbl_cnt", xfer_count, vecs[i].cnt_after);
      chk("tbl_ack", ack_tog_out, vecs[i].ack_after);
    end

    // Violation: second req toggle while a word is held
    data_in    = 32'hDEADBEEF;
    req_tog_in = ~req_tog_in;
    wait_valid(n);
    chk("viol_lat", n, LAT);
    data_in    = 32'h12345678;
    req_tog_in = ~req_tog_in;
    repeat (10) tick();
    chk("viol_err", err_sticky, 1'b1);
    chk("viol_data", data_out, 32'hDEADBEEF);
    chk("viol_valid", data_valid, 1'b1);
    chk("viol_ack_held", ack_tog_out, exp_ack);
    data_ready = 1'b1;
    tick();
    exp_ack = ~exp_ack;
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    chk("viol_acc_ack", ack_tog_out, exp_ack);
    data_ready = 1'b0;
    repeat (12) tick();
    chk("viol_one_ack", ack_tog_out, exp_ack);
    chk("viol_no_recap", data_valid, 1'b0);
    chk("viol_cnt", xfer_count, exp_cnt);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clr", err_sticky, 1'b0);

    // err_clr coinciding with a violation edge: set wins
    data_in    = 32'h00000055;
    req_tog_in = ~req_tog_in;
    wait_valid(n);
    req_tog_in = ~req_tog_in;
    repeat (6) tick();
    chk("clr_pre_err", err_sticky, 1'b0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_vs_set", err_sticky, 1'b1);
    data_ready = 1'b1;
    tick();
    exp_ack = ~exp_ack;
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    data_ready = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    repeat (10) tick();

    // Reset mid-HOLD with req parked at 1
    if (req_tog_in) do_xfer($urandom, 0);
    data_in    = 32'h000000AA;
    req_tog_in = ~req_tog_in;
    wait_valid(n);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", data_valid, 1'b0);
    chk("mid_rst_ack", ack_tog_out, 1'b0);
    chk("mid_rst_cnt", xfer_count, 0);
    chk("mid_rst_data", data_out, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("init_ack_hold", ack_tog_out, 1'b0);
    tick();
    chk("init_ack_align", ack_tog_out, 1'b1);
    exp_ack = 1'b1;
    exp_cnt = 0;
    repeat (10) tick();
    chk("init_no_valid", data_valid, 1'b0);

    // Wrap: 17 back-to-back transfers, ready tied high, random data
    for (int i = 0; i < 17; i++) begin
      do_xfer($urandom, 0);
    end
    chk("wrap_cnt", xfer_count, 1);
    chk("wrap_err", err_sticky, 1'b0);

    // Randomized transfers with random backpressure
    for (int i = 0; i < 20; i++) begin
      do_xfer($urandom, int'($urandom_range(0, 3)));
    end
    chk("rand_err", err_sticky, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
